// File: rtl/bus_arbiter_pkg.sv
// Shared types for bus_arbiter: FSM state encoding and transaction owner encoding.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/bus_arbiter_grant.sv
// arb_grant: picks IFU or LSU for the next memory transaction and remembers the last grant.
// Define ARB_ROUND_ROBIN_EN to alternate on ties; otherwise LSU has fixed priority.
module arb_grant
  import bus_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic fire,
  output logic grant
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  // With fixed priority, last stays at IFU so a tie always resolves to LSU.
  localparam logic LAST_INIT = RR_EN ? OWN_LSU : OWN_IFU;

  logic last;

  always_comb begin
    grant = OWN_IFU;
    if (ifu_valid && lsu_valid) grant = ~last;
    else if (lsu_valid)         grant = OWN_LSU;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      last <= LAST_INIT;
    else if (fire) last <= RR_EN ? grant : OWN_IFU;
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory port between IFU and LSU, one transaction in flight.
// Tie-break policy is selected by the ARB_ROUND_ROBIN_EN macro (see arb_grant).
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [WIDTH-1:0]   ifu_addr,
  output logic               ifu_resp_valid,
  output logic [WIDTH-1:0]   ifu_rdata,
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [WIDTH-1:0]   lsu_addr,
  input  logic               lsu_wen,
  input  logic [WIDTH-1:0]   lsu_wdata,
  input  logic [WIDTH/8-1:0] lsu_wmask,
  output logic               lsu_resp_valid,
  output logic [WIDTH-1:0]   lsu_rdata,
  output logic               mem_req_valid,
  output logic [WIDTH-1:0]   mem_addr,
  output logic               mem_wen,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_wmask,
  input  logic               mem_req_ready,
  input  logic               mem_resp_valid,
  input  logic [WIDTH-1:0]   mem_rdata
);

  state_t             state, state_nxt;
  logic               owner;
  logic [WIDTH-1:0]   addr_q, wdata_q;
  logic               wen_q;
  logic [WIDTH/8-1:0] wmask_q;
  logic               grant, accept, fire;

  arb_grant u_grant (
    .clk       (clk),
    .rst       (rst),
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .fire      (fire),
    .grant     (grant)
  );

  // rst gates the readies so nothing is offered while reset is held.
  assign accept        = (state == IDLE) && rst;
  assign ifu_req_ready = accept && ifu_req_valid && (grant == OWN_IFU);
  assign lsu_req_ready = accept && lsu_req_valid && (grant == OWN_LSU);
  assign fire          = ifu_req_ready || lsu_req_ready;

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  always_comb begin
    state_nxt      = state;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    case (state)
      IDLE: if (fire) state_nxt = REQ;
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = RESP;
      end
      RESP: if (mem_resp_valid) begin
        state_nxt = IDLE;
        if (owner == OWN_LSU) begin
          lsu_resp_valid = 1'b1;
          lsu_rdata      = mem_rdata;
        end else begin
          ifu_resp_valid = 1'b1;
          ifu_rdata      = mem_rdata;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        owner <= grant;
        if (grant == OWN_LSU) begin
          addr_q  <= lsu_addr;
          wen_q   <= lsu_wen;
          wdata_q <= lsu_wdata;
          wmask_q <= lsu_wmask;
        end else begin
          addr_q  <= ifu_addr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: idle vector table, directed corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_wen, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic ifu_v;
    logic lsu_v;
    logic mresp;
    logic exp_ifu_rdy;
    logic exp_lsu_rdy;
  } vec_t;

  typedef struct {
    logic        lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } txn_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
  endtask

  // Zero-wait IFU fetch; LSU side carries junk store fields that must not leak in.
  task automatic ifu_fetch(input logic [31:0] a, input logic [31:0] d, input string tag);
    clear_inputs();
    lsu_wen = 1; lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 4'hF; lsu_addr = 32'h1234_0000;
    ifu_req_valid = 1; ifu_addr = a;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = d;
    mid();
    chk({tag, "_c0_ifu_rdy"}, ifu_req_ready, 1);
    chk({tag, "_c0_mreq"}, mem_req_valid, 0);
    chk({tag, "_c0_ifu_resp"}, ifu_resp_valid, 0);
    cyc();
    ifu_req_valid = 0; ifu_addr = 0;
    mid();
    chk({tag, "_c1_mreq"}, mem_req_valid, 1);
    chk({tag, "_c1_addr"}, mem_addr, a);
    chk({tag, "_c1_wen"}, mem_wen, 0);
    chk({tag, "_c1_wdata"}, mem_wdata, 0);
    chk({tag, "_c1_wmask"}, mem_wmask, 0);
    chk({tag, "_c1_ifu_resp"}, ifu_resp_valid, 0);
    cyc();
    ifu_req_valid = 1;
    mid();
    chk({tag, "_c2_ifu_resp"}, ifu_resp_valid, 1);
    chk({tag, "_c2_rdata"}, ifu_rdata, d);
    chk({tag, "_c2_lsu_resp"}, lsu_resp_valid, 0);
    chk({tag, "_c2_ifu_rdy"}, ifu_req_ready, 0);
    chk({tag, "_c2_mreq"}, mem_req_valid, 0);
    cyc();
    mid();
    chk({tag, "_c3_ifu_rdy"}, ifu_req_ready, 1);
    chk({tag, "_c3_ifu_resp"}, ifu_resp_valid, 0);
    chk({tag, "_c3_rdata"}, ifu_rdata, 0);
    #1 clear_inputs();
    cyc();
  endtask

  vec_t vecs[6];
  txn_t pend[$];

  initial begin
    logic        issued, m_last_lsu, win_lsu, idle, exp_mreq, deliver;
    logic        e_ifu_rdy, e_lsu_rdy, e_ifu_resp, e_lsu_resp;
    logic [31:0] exp_addr;
    txn_t        t;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, RR,   !RR };
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, RR,   !RR };

    // Reset held with requests pending: nothing offered, nothing driven.
    clear_inputs();
    ifu_req_valid = 1; lsu_req_valid = 1; mem_resp_valid = 1; mem_rdata = 32'hCAFE_F00D;
    cyc();
    mid();
    chk("rst_ifu_rdy", ifu_req_ready, 0);
    chk("rst_lsu_rdy", lsu_req_ready, 0);
    chk("rst_mreq", mem_req_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ifu_resp", ifu_resp_valid, 0);
    chk("rst_lsu_resp", lsu_resp_valid, 0);
    #1 clear_inputs();
    cyc();
    rst = 1;
    cyc();

    // Idle vectors: combinational readies, spurious memory responses ignored.
    foreach (vecs[i]) begin
      ifu_req_valid = vecs[i].ifu_v; lsu_req_valid = vecs[i].lsu_v;
      mem_resp_valid = vecs[i].mresp; mem_rdata = 32'hCAFE_F00D;
      mid();
      chk($sformatf("vec%0d_ifu_rdy", i), ifu_req_ready, vecs[i].exp_ifu_rdy);
      chk($sformatf("vec%0d_lsu_rdy", i), lsu_req_ready, vecs[i].exp_lsu_rdy);
      chk($sformatf("vec%0d_ifu_resp", i), ifu_resp_valid, 0);
      chk($sformatf("vec%0d_lsu_resp", i), lsu_resp_valid, 0);
      chk($sformatf("vec%0d_ifu_rdata", i), ifu_rdata, 0);
      chk($sformatf("vec%0d_lsu_rdata", i), lsu_rdata, 0);
      chk($sformatf("vec%0d_mreq", i), mem_req_valid, 0);
      #1 clear_inputs();
      cyc();
    end

    // Sustained contention, then IFU alone once LSU stops asking.
    for (int r = 0; r < 4; r++) begin
      clear_inputs();
      ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
      lsu_req_valid = (r < 3); lsu_addr = 32'h8000_2000;
      mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h5000_0000 + r;
      win_lsu = (r == 3) ? 1'b0 : (RR ? (r % 2 == 1) : 1'b1);
      exp_addr = win_lsu ? 32'h8000_2000 : 32'h8000_0100;
      mid();
      chk($sformatf("arb%0d_ifu_rdy", r), ifu_req_ready, !win_lsu);
      chk($sformatf("arb%0d_lsu_rdy", r), lsu_req_ready, win_lsu);
      cyc();
      mid();
      chk($sformatf("arb%0d_mreq", r), mem_req_valid, 1);
      chk($sformatf("arb%0d_addr", r), mem_addr, exp_addr);
      chk($sformatf("arb%0d_busy_rdy", r), ifu_req_ready | lsu_req_ready, 0);
      cyc();
      mid();
      chk($sformatf("arb%0d_ifu_resp", r), ifu_resp_valid, !win_lsu);
      chk($sformatf("arb%0d_lsu_resp", r), lsu_resp_valid, win_lsu);
      chk($sformatf("arb%0d_rdata", r), win_lsu ? lsu_rdata : ifu_rdata, 32'h5000_0000 + r);
      chk($sformatf("arb%0d_other_rdata", r), win_lsu ? ifu_rdata : lsu_rdata, 0);
      cyc();
    end
    clear_inputs();
    cyc();

    ifu_fetch(32'h8000_0000, 32'h0000_0413, "fetch");

    // Store with a stalled memory: latched fields must hold while LSU inputs change.
    clear_inputs();
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    mid();
    chk("st_lsu_rdy", lsu_req_ready, 1);
    cyc();
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk($sformatf("st_wait%0d_mreq", i), mem_req_valid, 1);
      chk($sformatf("st_wait%0d_addr", i), mem_addr, 32'h8000_1000);
      chk($sformatf("st_wait%0d_wen", i), mem_wen, 1);
      chk($sformatf("st_wait%0d_wdata", i), mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("st_wait%0d_wmask", i), mem_wmask, 4'hF);
      cyc();
    end
    mem_req_ready = 1;
    mid();
    chk("st_acc_mreq", mem_req_valid, 1);
    cyc();
    mem_req_ready = 0;
    mid();
    chk("st_resp_wait_mreq", mem_req_valid, 0);
    chk("st_resp_wait_lsu", lsu_resp_valid, 0);
    cyc();
    mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    mid();
    chk("st_ack_lsu", lsu_resp_valid, 1);
    chk("st_ack_ifu", ifu_resp_valid, 0);
    chk("st_ack_rdata", lsu_rdata, 32'h1234_5678);
    cyc();
    mid();
    chk("st_after_lsu", lsu_resp_valid, 0);
    chk("st_after_rdata", lsu_rdata, 0);
    #1 clear_inputs();
    cyc();

    // Reset during RESP aborts the transaction with no response.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0080; mem_req_ready = 1;
    cyc();
    ifu_req_valid = 0;
    cyc();
    mid();
    chk("rr_pre_resp", ifu_resp_valid, 0);
    #1;
    mem_resp_valid = 1; mem_rdata = 32'hBAD0_BAD0;
    ifu_req_valid = 1; lsu_req_valid = 1; rst = 0;
    #1;
    chk("rr_ifu_resp", ifu_resp_valid, 0);
    chk("rr_lsu_resp", lsu_resp_valid, 0);
    chk("rr_ifu_rdy", ifu_req_ready, 0);
    chk("rr_lsu_rdy", lsu_req_ready, 0);
    chk("rr_mreq", mem_req_valid, 0);
    chk("rr_addr", mem_addr, 0);
    cyc();
    chk("rr_held_resp", ifu_resp_valid, 0);
    clear_inputs();
    mem_resp_valid = 1;
    rst = 1;
    mid();
    chk("rr_rel_resp", ifu_resp_valid, 0);
    chk("rr_rel_mreq", mem_req_valid, 0);
    #1 clear_inputs();
    cyc();
    ifu_fetch(32'h8000_0040, 32'h0000_0013, "post_rst");

    // Randomized traffic against the transaction-level model.
    rst = 0;
    cyc();
    rst = 1;
    cyc();
    pend.delete();
    issued = 0;
    m_last_lsu = 1;
    for (int c = 0; c < 2000; c++) begin
      ifu_req_valid  = ($urandom_range(0, 2) != 0);
      lsu_req_valid  = ($urandom_range(0, 2) != 0);
      ifu_addr       = $urandom;
      lsu_addr       = $urandom;
      lsu_wen        = $urandom_range(0, 1);
      lsu_wdata      = $urandom;
      lsu_wmask      = 4'($urandom_range(0, 15));
      mem_req_ready  = ($urandom_range(0, 2) != 0);
      mem_resp_valid = ($urandom_range(0, 2) != 0);
      mem_rdata      = $urandom;
      mid();
      idle      = (pend.size() == 0);
      win_lsu   = lsu_req_valid && (!ifu_req_valid || (RR ? !m_last_lsu : 1'b1));
      e_lsu_rdy = idle && win_lsu;
      e_ifu_rdy = idle && ifu_req_valid && !win_lsu;
      exp_mreq  = !idle && !issued;
      deliver   = !idle && issued && mem_resp_valid;
      e_lsu_resp = deliver && pend[0].lsu;
      e_ifu_resp = deliver && !pend[0].lsu;
      chk("rnd_ifu_rdy", ifu_req_ready, e_ifu_rdy);
      chk("rnd_lsu_rdy", lsu_req_ready, e_lsu_rdy);
      chk("rnd_mreq", mem_req_valid, exp_mreq);
      chk("rnd_ifu_resp", ifu_resp_valid, e_ifu_resp);
      chk("rnd_lsu_resp", lsu_resp_valid, e_lsu_resp);
      chk("rnd_ifu_rdata", ifu_rdata, e_ifu_resp ? mem_rdata : 32'h0);
      chk("rnd_lsu_rdata", lsu_rdata, e_lsu_resp ? mem_rdata : 32'h0);
      if (exp_mreq) begin
        chk("rnd_addr", mem_addr, pend[0].addr);
        chk("rnd_wen", mem_wen, pend[0].wen);
        chk("rnd_wdata", mem_wdata, pend[0].wdata);
        chk("rnd_wmask", mem_wmask, pend[0].wmask);
      end
      if (deliver) begin
        void'(pend.pop_front());
        issued = 0;
      end else if (exp_mreq && mem_req_ready) begin
        issued = 1;
      end
      if (e_ifu_rdy || e_lsu_rdy) begin
        if (win_lsu) t = '{1'b1, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask};
        else         t = '{1'b0, ifu_addr, 1'b0, 32'h0, 4'h0};
        pend.push_back(t);
        m_last_lsu = win_lsu;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
